// File: rtl/keypad_event_if.sv
// CPU-side link of the keypad block: EX9E/EXA1 query and FX0A wait-for-key handshake.
interface keypad_event_if;
  logic       wait_req;
  logic [3:0] query_key;
  logic       query_pressed;
  logic       waiting;
  logic       key_valid;
  logic [3:0] key_idx;

  modport master (output wait_req, output query_key,
                  input query_pressed, input waiting, input key_valid, input key_idx);
  modport slave  (input wait_req, input query_key,
                  output query_pressed, output waiting, output key_valid, output key_idx);
endinterface

// File: rtl/keypad_event.sv
// CHIP-8 keypad front end: per-key stability filter, registered key query,
// and the FX0A press-then-release wait FSM.
module keypad_event #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [15:0]    keymap_in,
  output logic [15:0]    keys_stable,
  keypad_event_if.slave  cpu
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  logic [15:0] stable_reg, stable_next;
  logic [15:0] stable_d_reg;
  logic [7:0]  cnt_reg  [16];
  logic [7:0]  cnt_next [16];
  logic [15:0] press_edge;
  logic [3:0]  low_idx;
  logic        query_pressed_reg;
  logic [3:0]  key_idx_reg, key_idx_next;
  state_t      state_reg, state_next;

  // Each key runs its own counter; it only counts while raw and filtered levels disagree.
  for (genvar gi = 0; gi < 16; gi++) begin : g_filter
    logic differ;
    logic hit;
    assign differ          = keymap_in[gi] ^ stable_reg[gi];
    assign hit             = (cnt_reg[gi] == HOLD_LAST);
    assign stable_next[gi] = (differ && hit) ? keymap_in[gi] : stable_reg[gi];
    assign cnt_next[gi]    = (!differ || hit) ? 8'd0 : cnt_reg[gi] + 8'd1;
  end

  assign press_edge = stable_reg & ~stable_d_reg;

  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (press_edge[i]) low_idx = 4'(i);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stable_reg        <= '0;
      stable_d_reg      <= '0;
      query_pressed_reg <= 1'b0;
      key_idx_reg       <= 4'd0;
      state_reg         <= IDLE;
      for (int i = 0; i < 16; i++) cnt_reg[i] <= 8'd0;
    end else begin
      stable_reg        <= stable_next;
      stable_d_reg      <= stable_reg;
      query_pressed_reg <= stable_reg[cpu.query_key];
      key_idx_reg       <= key_idx_next;
      state_reg         <= state_next;
      for (int i = 0; i < 16; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  // Only fresh 0->1 edges of the filtered map qualify, so keys held on entry are ignored.
  always_comb begin
    state_next   = state_reg;
    key_idx_next = key_idx_reg;
    case (state_reg)
      IDLE: begin
        if (cpu.wait_req) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!cpu.wait_req) begin
          state_next = IDLE;
        end else if (press_edge != 16'd0) begin
          key_idx_next = low_idx;
          state_next   = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!cpu.wait_req) begin
          state_next = IDLE;
        end else if (!stable_reg[key_idx_reg]) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!cpu.wait_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign keys_stable       = stable_reg;
  assign cpu.query_pressed = query_pressed_reg;
  assign cpu.key_idx       = key_idx_reg;
  assign cpu.key_valid     = (state_reg == DONE);
  assign cpu.waiting       = (state_reg == WAIT_PRESS) || (state_reg == WAIT_RELEASE);

endmodule

// File: tb/tb_keypad_event.sv
// Directed bench for keypad_event: vector table for reset/filter/query,
// hand sequences for the FX0A handshake corners.
module tb_keypad_event;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] keymap_in;
  logic [15:0] keys_stable;

  keypad_event_if cpu_if ();

  keypad_event #(.HOLD_CYCLES(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .keymap_in   (keymap_in),
    .keys_stable (keys_stable),
    .cpu         (cpu_if.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic [15:0] km;
    logic        wreq;
    logic [3:0]  qk;
    logic [15:0] e_stable;
    logic        e_qp;
    logic        e_wait;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(logic rst, logic [15:0] km, logic wreq, logic [3:0] qk,
                              logic [15:0] e_stable, logic e_qp, logic e_wait, logic e_valid);
    vec_t v;
    v.rst = rst; v.km = km; v.wreq = wreq; v.qk = qk;
    v.e_stable = e_stable; v.e_qp = e_qp; v.e_wait = e_wait; v.e_valid = e_valid;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_idle_outs(input string name);
    check({name, ".waiting"}, {15'd0, cpu_if.waiting}, 16'd0);
    check({name, ".key_valid"}, {15'd0, cpu_if.key_valid}, 16'd0);
  endtask

  // Tick until key_valid rises or the budget runs out; a timeout counts as a failure.
  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!cpu_if.key_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, ".valid_in_time"}, {15'd0, cpu_if.key_valid}, 16'd1);
  endtask

  initial begin
    rst_in = 1'b1;
    keymap_in = 16'h0000;
    cpu_if.wait_req = 1'b0;
    cpu_if.query_key = 4'd0;

    // Reset with all keys pressed, then 4-cycle filter latency out of reset.
    add(1, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0);
    add(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    // 3-cycle glitch on key 5 is rejected.
    add(0, 16'h0020, 0, 5, 16'h0000, 0, 0, 0);
    add(0, 16'h0020, 0, 5, 16'h0000, 0, 0, 0);
    add(0, 16'h0020, 0, 5, 16'h0000, 0, 0, 0);
    add(0, 16'h0000, 0, 5, 16'h0000, 0, 0, 0);
    // 4-cycle hold on key 5 is accepted on the 4th edge.
    add(0, 16'h0020, 0, 5, 16'h0000, 0, 0, 0);
    add(0, 16'h0020, 0, 5, 16'h0000, 0, 0, 0);
    add(0, 16'h0020, 0, 5, 16'h0000, 0, 0, 0);
    add(0, 16'h0020, 0, 5, 16'h0020, 0, 0, 0);
    add(0, 16'h0020, 0, 5, 16'h0020, 1, 0, 0);
    // Key 5 falls and key 9 rises together, both on the same schedule.
    add(0, 16'h0200, 0, 0, 16'h0020, 0, 0, 0);
    add(0, 16'h0200, 0, 0, 16'h0020, 0, 0, 0);
    add(0, 16'h0200, 0, 0, 16'h0020, 0, 0, 0);
    add(0, 16'h0200, 0, 0, 16'h0200, 0, 0, 0);
    // Query sweep over keys_stable = 0x0200.
    for (int q = 0; q < 16; q++) add(0, 16'h0200, 0, 4'(q), 16'h0200, (q == 9), 0, 0);
    add(0, 16'h0200, 0, 0, 16'h0200, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_in = vecs[i].rst;
      keymap_in = vecs[i].km;
      cpu_if.wait_req = vecs[i].wreq;
      cpu_if.query_key = vecs[i].qk;
      tick();
      check($sformatf("vec%0d.keys_stable", i), keys_stable, vecs[i].e_stable);
      check($sformatf("vec%0d.query_pressed", i), {15'd0, cpu_if.query_pressed}, {15'd0, vecs[i].e_qp});
      check($sformatf("vec%0d.waiting", i), {15'd0, cpu_if.waiting}, {15'd0, vecs[i].e_wait});
      check($sformatf("vec%0d.key_valid", i), {15'd0, cpu_if.key_valid}, {15'd0, vecs[i].e_valid});
    end

    // Clear key 9.
    keymap_in = 16'h0000;
    repeat (4) tick();
    check("clear.keys_stable", keys_stable, 16'h0000);

    // FX0A basic: press A, release after 10 cycles.
    cpu_if.wait_req = 1'b1;
    tick();
    check("basic.waiting", {15'd0, cpu_if.waiting}, 16'd1);
    keymap_in = 16'h0400;
    repeat (10) tick();
    check("basic.still_waiting", {15'd0, cpu_if.waiting}, 16'd1);
    check("basic.no_valid_while_held", {15'd0, cpu_if.key_valid}, 16'd0);
    keymap_in = 16'h0000;
    wait_valid("basic", 20);
    check("basic.key_idx", {12'd0, cpu_if.key_idx}, 16'h000A);
    check("basic.not_waiting_in_done", {15'd0, cpu_if.waiting}, 16'd0);
    // Re-raised wait_req in DONE does not leave DONE.
    tick();
    check("basic.done_held", {15'd0, cpu_if.key_valid}, 16'd1);
    cpu_if.wait_req = 1'b0;
    tick();
    check_idle_outs("basic.drop");

    // Held key 3 never qualifies; 7 beats C; releasing C is ignored.
    keymap_in = 16'h0008;
    repeat (6) tick();
    cpu_if.wait_req = 1'b1;
    repeat (6) tick();
    check("held.waiting", {15'd0, cpu_if.waiting}, 16'd1);
    keymap_in = 16'h1088;
    repeat (6) tick();
    keymap_in = 16'h0088;
    repeat (6) tick();
    check("held.waiting_after_c_release", {15'd0, cpu_if.waiting}, 16'd1);
    check("held.no_valid_after_c_release", {15'd0, cpu_if.key_valid}, 16'd0);
    keymap_in = 16'h0008;
    wait_valid("held", 20);
    check("held.key_idx", {12'd0, cpu_if.key_idx}, 16'h0007);
    cpu_if.wait_req = 1'b0;
    tick();
    check_idle_outs("held.drop");
    keymap_in = 16'h0000;
    repeat (6) tick();

    // Abort during WAIT_RELEASE: no key_valid ever appears.
    cpu_if.wait_req = 1'b1;
    tick();
    keymap_in = 16'h0002;
    repeat (8) tick();
    check("abort.in_release", {15'd0, cpu_if.waiting}, 16'd1);
    cpu_if.wait_req = 1'b0;
    tick();
    check_idle_outs("abort.drop");
    keymap_in = 16'h0000;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        tick();
        if (cpu_if.key_valid) seen++;
      end
      check("abort.no_valid_pulse", 16'(seen), 16'd0);
    end

    // Reset during WAIT_PRESS with a held key and a live query.
    keymap_in = 16'h0004;
    cpu_if.query_key = 4'd2;
    repeat (6) tick();
    cpu_if.wait_req = 1'b1;
    repeat (2) tick();
    check("rst.pre_waiting", {15'd0, cpu_if.waiting}, 16'd1);
    check("rst.pre_query", {15'd0, cpu_if.query_pressed}, 16'd1);
    check("rst.pre_key_idx", {12'd0, cpu_if.key_idx}, 16'h0001);
    rst_in = 1'b1;
    tick();
    check("rst.keys_stable", keys_stable, 16'h0000);
    check("rst.query_pressed", {15'd0, cpu_if.query_pressed}, 16'd0);
    check("rst.key_idx", {12'd0, cpu_if.key_idx}, 16'h0000);
    check_idle_outs("rst");
    rst_in = 1'b0;
    cpu_if.wait_req = 1'b0;
    keymap_in = 16'h0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
